// File: rtl/instr_encoder.sv
// Instruction encoder: packs per-format field bundles into a 32-bit word,
// flags immediates that do not fit their field, and buffers results in a
// 2-entry FIFO with valid/ready handshakes on both sides.
module instr_encoder #(
  parameter logic CHECK_IMM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  opcode,
  input  logic [2:0]  instr_type,
  input  logic [3:0]  rde,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [3:0]  func,
  input  logic [23:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam logic [2:0] FMT_R = 3'b000;
  localparam logic [2:0] FMT_M = 3'b001;
  localparam logic [2:0] FMT_F = 3'b010;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        range_ok;
  logic        fmt_ok;

  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [32:0] mem_q [2];
  logic [32:0] mem_d [2];

  logic push;
  logic pop;

  // Reset holds in_ready high; otherwise ready only depends on the registered fill level.
  assign in_ready  = !rst_n || (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_word  = mem_q[rd_ptr_q][31:0];
  assign out_err   = mem_q[rd_ptr_q][32];
  assign err_count = err_count_q;

  assign push = in_valid && in_ready && rst_n;
  assign pop  = out_valid && out_ready;

  // Encode the bundle and decide whether the immediate fits the selected field as a signed value.
  always_comb begin
    enc_word = {24'h0, opcode};
    range_ok = 1'b1;
    fmt_ok   = 1'b1;
    case (instr_type)
      FMT_R: begin
        enc_word[31:8] = {imm[7:0], func, rs2, rs1, rde};
        range_ok       = (&imm[23:7]) || (~|imm[23:7]);
      end
      FMT_M: begin
        enc_word[31:8] = {imm[11:0], func, rs1, rde};
        range_ok       = (&imm[23:11]) || (~|imm[23:11]);
      end
      FMT_F: begin
        enc_word[31:8] = {imm[15:0], func, rde};
        range_ok       = (&imm[23:15]) || (~|imm[23:15]);
      end
      FMT_B: begin
        enc_word[31:8] = {imm[19:0], func};
        range_ok       = (&imm[23:19]) || (~|imm[23:19]);
      end
      FMT_J: begin
        enc_word[31:8] = imm;
      end
      default: begin
        fmt_ok = 1'b0;
      end
    endcase
    enc_err = CHECK_IMM && (!fmt_ok || !range_ok);
  end

  // Compute next FIFO contents, pointers, fill level and the saturating error counter.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_count_d = err_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {enc_err, enc_word};
      wr_ptr_d        = ~wr_ptr_q;
      if (enc_err && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards any queued words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_count_q <= err_count_d;
    end
  end

  // FIFO storage needs no reset since out_valid masks stale entries.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: scoreboard of expected words fed
// at accept time and drained by a monitor, plus directed checks on the
// handshake, error counter and reset behaviour. A second instance with
// immediate checking disabled runs on the same stimulus.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  opcode;
  logic [2:0]  instr_type;
  logic [3:0]  rde, rs1, rs2, func;
  logic [23:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_err;
  logic [7:0]  err_count;

  logic        nc_in_ready;
  logic        nc_out_valid;
  logic [31:0] nc_out_word;
  logic        nc_out_err;
  logic [7:0]  nc_err_count;

  int testCount = 0;
  int failCount = 0;
  int expErrCount = 0;
  logic [32:0] sbQ [$];

  instr_encoder #(.CHECK_IMM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .instr_type(instr_type), .rde(rde), .rs1(rs1),
    .rs2(rs2), .func(func), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_err(out_err),
    .err_count(err_count)
  );

  instr_encoder #(.CHECK_IMM(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nc_in_ready),
    .opcode(opcode), .instr_type(instr_type), .rde(rde), .rs1(rs1),
    .rs2(rs2), .func(func), .imm(imm), .out_valid(nc_out_valid),
    .out_ready(out_ready), .out_word(nc_out_word), .out_err(nc_out_err),
    .err_count(nc_err_count)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so a stuck handshake can never hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference encoding built arithmetically: shifts/masks for placement and
  // signed value bounds for the range check. Returns {err, word}.
  function automatic logic [32:0] model(input logic [2:0] t, input logic [7:0] op,
                                        input logic [3:0] d, input logic [3:0] s1,
                                        input logic [3:0] s2, input logic [3:0] f,
                                        input logic [23:0] im, input bit chk);
    logic [31:0] w;
    logic        e;
    int          width;
    int          sv;
    int          lim;
    w     = 32'(op);
    e     = 1'b0;
    width = 0;
    sv    = int'($signed(im));
    case (t)
      3'd0: begin
        w |= (32'(d) << 8) | (32'(s1) << 12) | (32'(s2) << 16) | (32'(f) << 20)
           | ((32'(im) & 32'h0000_00FF) << 24);
        width = 8;
      end
      3'd1: begin
        w |= (32'(d) << 8) | (32'(s1) << 12) | (32'(f) << 16)
           | ((32'(im) & 32'h0000_0FFF) << 20);
        width = 12;
      end
      3'd2: begin
        w |= (32'(d) << 8) | (32'(f) << 12) | ((32'(im) & 32'h0000_FFFF) << 16);
        width = 16;
      end
      3'd3: begin
        w |= (32'(f) << 8) | ((32'(im) & 32'h000F_FFFF) << 12);
        width = 20;
      end
      3'd4: begin
        w |= (32'(im) << 8);
      end
      default: e = 1'b1;
    endcase
    if (width != 0) begin
      lim = 1 << (width - 1);
      if (sv >= lim || sv < -lim) e = 1'b1;
    end
    if (!chk) e = 1'b0;
    return {e, w};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bundle, wait (bounded) for acceptance, record the expectation.
  task automatic applyStimulus(input logic [2:0] t, input logic [7:0] op,
                               input logic [3:0] d, input logic [3:0] s1,
                               input logic [3:0] s2, input logic [3:0] f,
                               input logic [23:0] im);
    logic [32:0] e;
    bit done;
    done       = 1'b0;
    instr_type = t;
    opcode     = op;
    rde        = d;
    rs1        = s1;
    rs2        = s2;
    func       = f;
    imm        = im;
    in_valid   = 1'b1;
    e = model(t, op, d, s1, s2, f, im, 1'b1);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready && rst_n) begin
        sbQ.push_back(e);
        if (e[32] && expErrCount < 255) expErrCount++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("accept_timeout", 32'(done), 32'd1);
  endtask

  // Scoreboard monitor: compare every word the consumer takes.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_word", 32'(sbQ.size()), 32'd1);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_word", out_word, e[31:0]);
        checkOutput("sb_err", 32'(out_err), 32'(e[32]));
        checkOutput("sb_nc_valid", 32'(nc_out_valid), 32'd1);
        checkOutput("sb_nc_word", nc_out_word, e[31:0]);
        checkOutput("sb_nc_err", 32'(nc_out_err), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic [31:0] aWord;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    opcode     = 8'h00;
    instr_type = 3'b000;
    rde        = 4'h0;
    rs1        = 4'h0;
    rs2        = 4'h0;
    func       = 4'h0;
    imm        = 24'h0;

    // Reset state
    @(posedge clk); #1;
    checkOutput("in_ready_during_reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_err_count", 32'(err_count), 32'd0);

    // Format R, one cycle latency
    out_ready = 1'b1;
    applyStimulus(3'b000, 8'h20, 4'd1, 4'd2, 4'd3, 4'd4, 24'h000055);
    checkOutput("r_out_valid", 32'(out_valid), 32'd1);
    checkOutput("r_word", out_word, 32'h55432120);
    checkOutput("r_err", 32'(out_err), 32'd0);

    // Format M overflow (pushed while R pops), then fitting negative value
    applyStimulus(3'b001, 8'h40, 4'd0, 4'd0, 4'd0, 4'd0, 24'h000800);
    checkOutput("m_ovf_word", out_word, 32'h80000040);
    checkOutput("m_ovf_err", 32'(out_err), 32'd1);
    checkOutput("m_ovf_err_count", 32'(err_count), 32'd1);
    applyStimulus(3'b001, 8'h40, 4'd0, 4'd0, 4'd0, 4'd0, 24'hFFF800);
    checkOutput("m_neg_word", out_word, 32'h80000040);
    checkOutput("m_neg_err", 32'(out_err), 32'd0);
    checkOutput("m_neg_err_count", 32'(err_count), 32'd1);
    @(posedge clk); #1;

    // Backpressure: two fill the FIFO, third waits until a pop
    out_ready = 1'b0;
    aWord = model(3'b010, 8'h11, 4'h5, 4'h0, 4'h0, 4'h6, 24'h001234, 1'b1);
    applyStimulus(3'b010, 8'h11, 4'h5, 4'h0, 4'h0, 4'h6, 24'h001234);
    applyStimulus(3'b011, 8'h22, 4'h0, 4'h0, 4'h0, 4'h7, 24'h0ABCDE);
    checkOutput("bp_in_ready_full", 32'(in_ready), 32'd0);
    checkOutput("bp_head_word", out_word, aWord);
    fork
      applyStimulus(3'b100, 8'h33, 4'h0, 4'h0, 4'h0, 4'h0, 24'hFEDCBA);
      begin
        @(posedge clk); #1;
        checkOutput("bp_in_ready_held", 32'(in_ready), 32'd0);
        checkOutput("bp_head_stable", out_word, aWord);
        checkOutput("bp_head_err_stable", 32'(out_err), 32'd0);
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Random bundles across all formats
    for (int i = 0; i < 24; i++) begin
      r = $urandom;
      if (r[31]) imm = {{16{r[7]}}, r[7:0]};
      else       imm = r[23:0];
      applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom), 4'($urandom),
                    4'($urandom), 4'($urandom), imm);
    end
    checkOutput("rand_err_count", 32'(err_count), 32'(expErrCount));

    // Invalid format
    applyStimulus(3'b110, 8'hAB, 4'hF, 4'hF, 4'hF, 4'hF, 24'h000000);
    checkOutput("inv_word", out_word, 32'h000000AB);
    checkOutput("inv_err", 32'(out_err), 32'd1);
    checkOutput("inv_nc_err", 32'(nc_out_err), 32'd0);
    checkOutput("inv_err_count", 32'(err_count), 32'(expErrCount));
    checkOutput("inv_nc_err_count", 32'(nc_err_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-stream with two words queued
    out_ready = 1'b0;
    applyStimulus(3'b111, 8'h01, 4'h0, 4'h0, 4'h0, 4'h0, 24'h0);
    applyStimulus(3'b000, 8'h02, 4'h1, 4'h1, 4'h1, 4'h1, 24'h0);
    checkOutput("mid_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_in_ready_in_reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sbQ.delete();
    expErrCount = 0;
    checkOutput("mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_err_count", 32'(err_count), 32'd0);
    checkOutput("mid_nc_in_ready", 32'(nc_in_ready), 32'd1);
    out_ready = 1'b1;

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) begin
      applyStimulus(3'b111, 8'(i), 4'h0, 4'h0, 4'h0, 4'h0, 24'h0);
      if (i == 253) checkOutput("sat_pre_count", 32'(err_count), 32'd254);
    end
    checkOutput("sat_err_count", 32'(err_count), 32'hFF);
    checkOutput("sat_nc_err_count", 32'(nc_err_count), 32'd0);

    // Drain and confirm every expected word was seen
    repeat (4) @(posedge clk);
    #1;
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter CHECK_IMM, default 1: 1 enables immediate-range and format checking; 0 disables it, so err is forced 0.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: field bundle valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a bundle.
REQ-006 SHALL have port opcode, input, 8 bits: instruction opcode.
REQ-007 SHALL have port instr_type, input, 3 bits: format code.
REQ-008 SHALL have ports rde, rs1, rs2 and func, input, 4 bits each: register and function fields.
REQ-009 SHALL have port imm, input, 24 bits: immediate, two's complement.
REQ-010 SHALL have port out_valid, output, 1 bit: encoded word available.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts word.
REQ-012 SHALL have port out_word, output, 32 bits: encoded instruction.
REQ-013 SHALL have port out_err, output, 1 bit: error flag sideband to out_word.
REQ-014 SHALL have port err_count, output, 8 bits: saturating count of errored words accepted.

Function
REQ-015 SHALL place opcode in bits [7:0] for every format.
REQ-016 SHALL encode format R (3'b000) as: rde [11:8], rs1 [15:12], rs2 [19:16], func [23:20], imm[7:0] [31:24].
REQ-017 SHALL encode format M (3'b001) as: rde [11:8], rs1 [15:12], func [19:16], imm[11:0] [31:20].
REQ-018 SHALL encode format F (3'b010) as: rde [11:8], func [15:12], imm[15:0] [31:16].
REQ-019 SHALL encode format B (3'b011) as: func [11:8], imm[19:0] [31:12].
REQ-020 SHALL encode format J (3'b100) as: imm[23:0] [31:8].
REQ-021 SHALL ignore inputs unused by the selected format.
REQ-022 SHALL, for instr_type 3'b101–3'b111, output out_word = {24'h0, opcode} with error.
REQ-023 SHALL set error (CHECK_IMM=1) when imm bits above the field width W do not all equal imm[W-1], i.e. the value does not fit W-bit signed; the word is still emitted with imm truncated to W bits; J format never range-errors.
REQ-024 SHALL accept a bundle when in_valid && in_ready at a rising edge.
REQ-025 SHALL write the encoded word and error into a 2-entry FIFO on accept; encoding is combinational before the FIFO write.
REQ-026 SHALL give a latency of 1 cycle: a bundle accepted at edge N appears on out_word/out_valid after edge N if the FIFO was empty; no combinational in_valid->out_valid path.
REQ-027 SHALL drive in_ready = (FIFO count < 2) from registered count only; there is no out_ready->in_ready combinational path.
REQ-028 SHALL pop the FIFO head when out_valid && out_ready; when count==1, a simultaneous push and pop leaves count 1 with the new word at the head.
REQ-029 SHALL hold out_word/out_err stable while out_valid && !out_ready.
REQ-030 SHALL preserve word order (FIFO); pointers wrap modulo 2.
REQ-031 SHALL drive out_valid = (count != 0); out_word/out_err are don't-care when out_valid=0.
REQ-032 SHALL increment err_count on each accepted errored bundle and saturate at 8'hFF.

Reset
REQ-033 SHALL, when rst_n=0 at a rising edge, set count=0, pointers=0 and err_count=0; out_valid=0 and in_ready=1 afterwards.
REQ-034 SHALL let reset override a simultaneous push or pop; FIFO contents are discarded mid-stream.
REQ-035 SHALL keep in_ready=1 during reset, though no bundle is accepted while rst_n=0.

Verification
REQ-036 SHALL cover format R: opcode 8'h20, rde 1, rs1 2, rs2 3, func 4, imm 24'h000055, out_ready=1 -> out_word 32'h55432120, out_err 0, one cycle after accept.
REQ-037 SHALL cover format M overflow: opcode 8'h40, imm 24'h000800 -> out_err 1, imm field 12'h800, err_count increments to 1; imm 24'hFFF800 -> out_err 0.
REQ-038 SHALL cover backpressure: out_ready=0, three back-to-back bundles -> in_ready falls after the second accept, third held; out_ready=1 -> words emitted in order, third accepted afterwards.
REQ-039 SHALL cover invalid format: instr_type 3'b110, opcode 8'hAB -> out_word 32'h000000AB, out_err 1; with CHECK_IMM=0 -> out_err 0, err_count stays 0.
REQ-040 SHALL cover reset mid-stream: two words queued, rst_n=0 for one edge -> out_valid 0, in_ready 1, err_count 0 on the next cycle.
REQ-041 SHALL cover saturation: 260 errored bundles -> err_count holds 8'hFF.
